// File: rtl/uart_rx_ctrl_if.sv
// Peripheral-bus port bundle for uart_rx_ctrl: request/ready handshake,
// read data and the level interrupt line.
interface uart_rx_ctrl_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  modport master (
    output sel, we, addr, wdata,
    input  rdata, ready, irq
  );

  modport slave (
    input  sel, we, addr, wdata,
    output rdata, ready, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: byte FIFO with overrun tracking, DATA/STATUS/CTRL
// registers behind a one-wait-state bus, level irq. Optional idle timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  uart_rx_ctrl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          rx_en_q, rx_en_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic not_empty, full, resp;
  logic rd_acc, wr_acc, pop, flush, sts_wr, ctrl_wr;
  logic push_req, push_acc, ovr_set;
  logic timeout_bit;
  logic [31:0] rdata_mux;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign resp      = (state_q == S_RESP);

  // All register side effects happen in the single ready cycle.
  assign rd_acc  = resp && !bus.we;
  assign wr_acc  = resp && bus.we;
  assign pop     = rd_acc && (bus.addr == ADDR_DATA) && not_empty;
  assign sts_wr  = wr_acc && (bus.addr == ADDR_STATUS);
  assign ctrl_wr = wr_acc && (bus.addr == ADDR_CTRL);
  assign flush   = ctrl_wr && bus.wdata[2];

  assign push_req = rx_done && rx_en_q;
  assign push_acc = push_req && (!full || pop) && !flush;
  assign ovr_set  = push_req && full && !pop && !flush;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (push_acc || pop || flush || !not_empty) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (sts_wr && bus.wdata[3]) timeout_d = 1'b0;
    if (pop) timeout_d = 1'b0;
    // Fires once on reaching the threshold, so a W1C is not immediately undone.
    else if (tmo_cnt_d == TW'(TIMEOUT_CYCLES) && tmo_cnt_q != TW'(TIMEOUT_CYCLES))
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_bit = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign timeout_bit = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:4];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    rx_en_d   = rx_en_q;
    irq_en_d  = irq_en_q;

    case (state_q)
      S_IDLE:  if (bus.sel) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push_acc) count_d = count_q - 1'b1;
    end

    if (sts_wr && bus.wdata[2]) overrun_d = 1'b0;
    if (ovr_set)                overrun_d = 1'b1;

    if (ctrl_wr) begin
      rx_en_d  = bus.wdata[0];
      irq_en_d = bus.wdata[1];
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (bus.addr)
      ADDR_DATA:   if (not_empty) rdata_mux = {24'h0, mem_q[rd_ptr_q]};
      ADDR_STATUS: rdata_mux = {16'h0, 8'(count_q), 4'h0,
                                timeout_bit, overrun_q, full, not_empty};
      ADDR_CTRL:   rdata_mux = {30'h0, irq_en_q, rx_en_q};
      default:     rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rx_en_q   <= 1'b1;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      rx_en_q   <= rx_en_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_en_q && (not_empty || overrun_q || timeout_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rx_data;
  end

  assign bus.ready = resp;
  assign bus.rdata = rd_acc ? rdata_mux : 32'h0;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver queues expected read data per access,
// a negedge monitor compares whenever ready is seen.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h0;
  logic       rx_done = 1'b0;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(800)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string nm = name_q.pop_front();
        check(nm, bus_if.rdata, e);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // One bus access; optionally raise rx_done in the ready cycle.
  task automatic access(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm,
                        input logic push_en = 1'b0, input logic [7:0] pb = 8'h0);
    int n;
    logic got;
    exp_q.push_back(w ? 32'h0 : exp);
    name_q.push_back(nm);
    bus_if.sel = 1'b1;
    bus_if.we = w;
    bus_if.addr = a;
    bus_if.wdata = d;
    got = 1'b0;
    for (n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (bus_if.ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({nm, "_ready_timeout"}, 32'd0, 32'd1);
      bus_if.sel = 1'b0;
    end else begin
      check({nm, "_ready_latency"}, n, 0);
      if (push_en) begin
        rx_data = pb;
        rx_done = 1'b1;
      end
      @(posedge clk); #1;
      rx_done = 1'b0;
      bus_if.sel = 1'b0;
      check({nm, "_ready_width"}, {31'h0, bus_if.ready}, 32'h0);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    access(1'b0, a, 32'h0, exp, nm);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string nm);
    access(1'b1, a, d, 32'h0, nm);
  endtask

  initial begin
    bus_if.sel = 1'b0;
    bus_if.we = 1'b0;
    bus_if.addr = 4'h0;
    bus_if.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("irq_after_reset", {31'h0, bus_if.irq}, 32'h0);
    rd(4'h4, 32'h0000_0000, "status_reset");
    rd(4'h8, 32'h0000_0001, "ctrl_reset");

    // Basic push/pop ordering
    push_byte(8'h55);
    push_byte(8'hA3);
    rd(4'h4, 32'h0000_0201, "status_two");
    rd(4'h0, 32'h0000_0055, "data_first");
    rd(4'h0, 32'h0000_00A3, "data_second");
    rd(4'h4, 32'h0000_0000, "status_drained");
    rd(4'h0, 32'h0000_0000, "data_empty");
    rd(4'h4, 32'h0000_0000, "status_after_empty_read");

    // Overflow with 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
    rd(4'h4, 32'h0000_1007, "status_overrun");
    wr(4'h4, 32'h0000_0004, "w1c_overrun");
    rd(4'h4, 32'h0000_1003, "status_ovr_cleared");
    rd(4'h0, 32'h0000_0010, "data_head_after_ovr");

    // Refill to full, then pop and push in the same cycle
    push_byte(8'h40);
    rd(4'h4, 32'h0000_1003, "status_refull");
    access(1'b0, 4'h0, 32'h0, 32'h0000_0011, "data_pop_push", 1'b1, 8'h41);
    rd(4'h4, 32'h0000_1003, "status_pop_push");
    for (int i = 0; i < 14; i++)
      rd(4'h0, 32'h0000_0012 + 32'(i), $sformatf("drain_%0d", i));
    rd(4'h0, 32'h0000_0040, "drain_40");
    rd(4'h0, 32'h0000_0041, "drain_last_41");
    rd(4'h4, 32'h0000_0000, "status_after_drain");

    // Interrupt, flush beating a same-cycle push, rx disable
    wr(4'h8, 32'h0000_0003, "ctrl_irq_en");
    rd(4'h8, 32'h0000_0003, "ctrl_rb3");
    push_byte(8'h77);
    @(posedge clk); #1;
    check("irq_set", {31'h0, bus_if.irq}, 32'h1);
    access(1'b1, 4'h8, 32'h0000_0007, 32'h0, "ctrl_flush", 1'b1, 8'h88);
    @(posedge clk); #1;
    check("irq_clear_after_flush", {31'h0, bus_if.irq}, 32'h0);
    rd(4'h8, 32'h0000_0003, "ctrl_after_flush");
    rd(4'h4, 32'h0000_0000, "status_after_flush");
    wr(4'h8, 32'h0000_0000, "ctrl_rx_dis");
    push_byte(8'h99);
    rd(4'h4, 32'h0000_0000, "status_rx_dis");

    // Reserved address and ignored DATA write
    wr(4'hC, 32'hFFFF_FFFF, "wr_reserved");
    rd(4'hC, 32'h0000_0000, "rd_reserved");
    wr(4'h0, 32'h0000_00AB, "wr_data");
    rd(4'h4, 32'h0000_0000, "status_after_data_wr");
    rd(4'h8, 32'h0000_0000, "ctrl_after_reserved");

    // Idle timeout
    wr(4'h8, 32'h0000_0001, "ctrl_rx_en");
    push_byte(8'h5A);
    repeat (805) @(posedge clk);
    #1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    rd(4'h4, 32'h0000_0109, "status_timeout");
`else
    rd(4'h4, 32'h0000_0101, "status_no_timeout");
`endif
    rd(4'h0, 32'h0000_005A, "data_timeout_byte");
    rd(4'h4, 32'h0000_0000, "status_after_timeout_pop");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
